// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder built-in self-test engine.
// Holds the FSM state encoding, the default vector width and the golden add.
// Everything here is combinational or declarative; no storage.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default operand width and the matching {a,b,cin} vector width.
  localparam int W_DEF = 4;
  localparam int VEC_W = 2 * W_DEF + 1;

  // Widest operand the golden add supports; callers zero-extend into it.
  localparam int GOLD_W = 16;

  // Full-precision reference add: result is one bit wider than the operands.
  function automatic logic [GOLD_W:0] golden_add(input logic [GOLD_W-1:0] a,
                                                 input logic [GOLD_W-1:0] b,
                                                 input logic              cin);
    return {1'b0, a} + {1'b0, b} + {{GOLD_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/adder_bist_engine_golden.sv
// Combinational W-bit reference adder producing {carry_out, sum}.
// Latency: zero cycles (pure combinational).
// No flow control; the result tracks the operands continuously.
module adder_golden_model
  import adder_bist_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W:0]   sum_o
);

  // Zero-extend into the package add, keep the W+1 meaningful result bits.
  assign sum_o = (W+1)'(golden_add(GOLD_W'(a_i), GOLD_W'(b_i), cin_i));

endmodule

// File: rtl/adder_bist_engine.sv
// Exhaustive {a,b,cin} sweep of an external W-bit adder with on-chip compare.
// Each vector is held SETTLE cycles then sampled once: SETTLE+1 cycles per vector.
// start is honoured only in IDLE or DONE; a pulse during a sweep is dropped.
module adder_bist_engine
  import adder_bist_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  output logic             dut_cin,
  input  logic [W-1:0]     dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2*W:0]     first_fail_vec
);

  localparam int             VW          = 2 * W + 1;
  localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [VW-1:0]  VEC_LAST    = '1;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t            state_q, state_d;
  logic [VW-1:0]     vec_q, vec_d;
  logic [3:0]        settle_q, settle_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_vld_q, fail_vld_d;
  logic [VW-1:0]     ffv_q, ffv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [W:0]        golden_sum;
  logic              mismatch;

  // The vector register feeds the adder directly, so the operands only move
  // when vec_q is reloaded, which happens only on entry to APPLY.
  assign dut_a          = vec_q[VW-1 -: W];
  assign dut_b          = vec_q[W:1];
  assign dut_cin        = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fail_vld_q;
  assign first_fail_vec = ffv_q;

  adder_golden_model #(.W(W)) u_golden (
    .a_i   (vec_q[VW-1 -: W]),
    .b_i   (vec_q[W:1]),
    .cin_i (vec_q[0]),
    .sum_o (golden_sum)
  );

  assign mismatch = ({dut_cout, dut_sum} != golden_sum);

  // State and result registers; reset drops everything to zero and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      ffv_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      ffv_q      <= ffv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  // Next-state logic: sweep sequencing, settle countdown, compare and capture.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    err_d      = err_q;
    fail_vld_d = fail_vld_q;
    ffv_d      = ffv_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = APPLY;
          vec_d      = '0;
          settle_d   = SETTLE_LOAD;
          err_d      = '0;
          fail_vld_d = 1'b0;
          ffv_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      APPLY: begin
        if (settle_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          // Saturate rather than wrap so a huge fault count never reads as pass.
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!fail_vld_q) begin
            fail_vld_d = 1'b1;
            ffv_d      = vec_q;
          end
        end
        // Terminal vector is detected by value so the counter never wraps.
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = APPLY;
          vec_d    = vec_q + 1'b1;
          settle_d = SETTLE_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adder_bist_engine.sv
module tb_adder_bist_engine;
  import adder_bist_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   fault = 0;   // 0 clean, 1 carry_out stuck-at-0, 2 sum[0] stuck-at-1

  // Primary engine, ERR_W=10.
  logic [W-1:0]     a1, b1, s1;
  logic             c1, co1, busy1, done1, pass1, fv1;
  logic [9:0]       err1;
  logic [VEC_W-1:0] ffv1;

  // Second engine with a narrow counter for saturation.
  logic [W-1:0]     a2, b2, s2;
  logic             c2, co2, busy2, done2, pass2, fv2;
  logic [3:0]       err2;
  logic [VEC_W-1:0] ffv2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Adder under test with optional injected fault.
  function automatic logic [W:0] faulty_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c, input int f);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    if (f == 1) r[W] = 1'b0;
    if (f == 2) r[0] = 1'b1;
    return r;
  endfunction

  assign {co1, s1} = faulty_add(a1, b1, c1, fault);
  assign {co2, s2} = faulty_add(a2, b2, c2, fault);

  adder_bist_engine #(.W(W), .SETTLE(1), .ERR_W(10)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(a1), .dut_b(b1), .dut_cin(c1), .dut_sum(s1), .dut_cout(co1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_vec(ffv1)
  );

  adder_bist_engine #(.W(W), .SETTLE(1), .ERR_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(a2), .dut_b(b2), .dut_cin(c2), .dut_sum(s2), .dut_cout(co2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .first_fail_vec(ffv2)
  );

  // Pulse start, report busy right after it and the busy-cycle count to done.
  task automatic run_sweep(output logic busy_seen, output int cyc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    busy_seen = busy1;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1, done1, pass1, fv1} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=0000", {busy1, done1, pass1, fv1});
    end
    checks++;
    if ({err1, ffv1, a1, b1, c1} !== '0) begin
      errors++; $display("FAIL reset_data got err=%0d ffv=%h a=%0d b=%0d cin=%0d want all 0",
                         err1, ffv1, a1, b1, c1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL idle_no_start got busy=%b want 0", busy1);
    end
  endtask

  task automatic test_clean_sweep();
    logic bs; int cyc;
    fault = 0;
    run_sweep(bs, cyc);
    checks++;
    if (bs !== 1'b1) begin errors++; $display("FAIL clean_busy_rise got=%b want=1", bs); end
    checks++;
    if (cyc != 1024) begin errors++; $display("FAIL clean_cycles got=%0d want=1024", cyc); end
    checks++;
    if ({pass1, err1, fv1, busy1} !== {1'b1, 10'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clean_result got pass=%b err=%0d fv=%b busy=%b want 1/0/0/0",
                         pass1, err1, fv1, busy1);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done1 !== 1'b1) begin errors++; $display("FAIL done_held got=%b want=1", done1); end
  endtask

  task automatic test_cout_stuck();
    logic bs; int cyc;
    fault = 1;
    run_sweep(bs, cyc);
    checks++;
    if (cyc != 1024) begin errors++; $display("FAIL cout_cycles got=%0d want=1024", cyc); end
    checks++;
    if (err1 !== 10'd256) begin errors++; $display("FAIL cout_err got=%0d want=256", err1); end
    checks++;
    if ({pass1, fv1} !== 2'b01) begin
      errors++; $display("FAIL cout_flags got pass=%b fv=%b want 0/1", pass1, fv1);
    end
    checks++;
    if (ffv1 !== 9'h01F) begin errors++; $display("FAIL cout_first got=%h want=01f", ffv1); end
  endtask

  task automatic test_sum0_stuck();
    logic bs; int cyc;
    fault = 2;
    run_sweep(bs, cyc);
    checks++;
    if (err1 !== 10'd256) begin errors++; $display("FAIL sum0_err got=%0d want=256", err1); end
    checks++;
    if (ffv1 !== 9'h000 || fv1 !== 1'b1 || pass1 !== 1'b0) begin
      errors++; $display("FAIL sum0_first got ffv=%h fv=%b pass=%b want 000/1/0", ffv1, fv1, pass1);
    end
  endtask

  task automatic test_saturation();
    logic bs; int cyc;
    fault = 1;
    run_sweep(bs, cyc);
    checks++;
    if (done2 !== 1'b1) begin errors++; $display("FAIL sat_done got=%b want=1", done2); end
    checks++;
    if (err2 !== 4'd15) begin errors++; $display("FAIL sat_err got=%0d want=15", err2); end
    checks++;
    if (pass2 !== 1'b0 || ffv2 !== 9'h01F || fv2 !== 1'b1) begin
      errors++; $display("FAIL sat_flags got pass=%b ffv=%h fv=%b want 0/01f/1", pass2, ffv2, fv2);
    end
  endtask

  task automatic test_reset_mid();
    logic bs; int cyc;
    fault = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (200) @(negedge clk);
    checks++;
    if ({a1, b1, c1} !== 9'd100) begin
      errors++; $display("FAIL mid_vector got=%0d want=100", {a1, b1, c1});
    end
    checks++;
    if (err1 !== 10'd9 || ffv1 !== 9'h01F) begin
      errors++; $display("FAIL mid_partial got err=%0d ffv=%h want 9/01f", err1, ffv1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy1, done1, pass1, fv1, err1, ffv1, a1, b1, c1} !== '0) begin
      errors++; $display("FAIL mid_reset got busy=%b done=%b err=%0d ffv=%h vec=%0d want all 0",
                         busy1, done1, err1, ffv1, {a1, b1, c1});
    end
    @(negedge clk) rst = 1'b0;
    fault = 0;
    run_sweep(bs, cyc);
    checks++;
    if (bs !== 1'b1 || cyc != 1024) begin
      errors++; $display("FAIL post_reset_sweep got busy=%b cycles=%0d want 1/1024", bs, cyc);
    end
    checks++;
    if ({pass1, err1, fv1} !== {1'b1, 10'd0, 1'b0}) begin
      errors++; $display("FAIL post_reset_result got pass=%b err=%0d fv=%b want 1/0/0", pass1, err1, fv1);
    end
  endtask

  task automatic test_restart();
    logic bs; int cyc;
    fault = 1;
    run_sweep(bs, cyc);
    fault = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({busy1, done1, err1, fv1} !== {1'b1, 1'b0, 10'd0, 1'b0}) begin
      errors++; $display("FAIL restart_clear got busy=%b done=%b err=%0d fv=%b want 1/0/0/0",
                         busy1, done1, err1, fv1);
    end
    cyc = 0;
    repeat (50) begin @(negedge clk); cyc++; end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc++;
    checks++;
    if (busy1 !== 1'b1 || {a1, b1, c1} !== 9'd25) begin
      errors++; $display("FAIL mid_start_ignored got busy=%b vec=%0d want 1/25", busy1, {a1, b1, c1});
    end
    while (done1 !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 1024) begin errors++; $display("FAIL restart_cycles got=%0d want=1024", cyc); end
    checks++;
    if (pass1 !== 1'b1 || err1 !== 10'd0) begin
      errors++; $display("FAIL restart_result got pass=%b err=%0d want 1/0", pass1, err1);
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_cout_stuck();
    test_sum0_stuck();
    test_saturation();
    test_reset_mid();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
